// File: rtl/cpu_fetch.sv
// Instruction fetch unit: reads a 1-3 byte instruction from byte-wide memory and presents it with a valid/ready handshake.
// Optional macro FETCH_ILLEGAL_TRAP_EN: cc=11 opcodes are flagged illegal and held in VALID until pc_load or rst.
module cpu_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0200
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  opcode,
  output logic [15:0] operand,
  output logic [15:0] instr_pc,
  output logic [1:0]  instr_len,
  output logic        instr_illegal
);

  typedef enum logic [2:0] {
    FETCH_OP,
    WAIT_OP,
    WAIT_LO,
    WAIT_HI,
    VALID
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [7:0]  r_opcode;
  logic [15:0] r_operand;
  logic [15:0] r_instr_pc;
  logic [1:0]  r_len;
  logic        r_illegal;
  logic        r_valid;

  logic [1:0]  w_op_len;
  logic        w_op_illegal;

  // Length from the {aaa,bbb,cc} opcode fields.
  function automatic logic [1:0] decode_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    case (op[1:0])
      2'b01: len = (op[4:2] inside {3'b011, 3'b110, 3'b111}) ? 2'd3 : 2'd2;
      2'b10: begin
        if (op[4:2] inside {3'b011, 3'b111})              len = 2'd3;
        else if (op[4:2] inside {3'b000, 3'b001, 3'b101}) len = 2'd2;
        else                                              len = 2'd1;
      end
      2'b00: begin
        if (op[4:2] == 3'b000) begin
          if (op == 8'h20)                          len = 2'd3;
          else if (op inside {8'h00, 8'h40, 8'h60}) len = 2'd1;
          else                                      len = 2'd2;
        end
        else if (op[4:2] inside {3'b011, 3'b111}) len = 2'd3;
        else if (op[4:2] inside {3'b010, 3'b110}) len = 2'd1;
        else                                      len = 2'd2;
      end
      default: len = 2'd1;
    endcase
    return len;
  endfunction

  assign w_op_len = decode_len(mem_rdata);

`ifdef FETCH_ILLEGAL_TRAP_EN
  assign w_op_illegal = (mem_rdata[1:0] == 2'b11);
`else
  assign w_op_illegal = 1'b0;
`endif

  // Read strobe is combinational so a redirect or reset suppresses it in the same cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    mem_rd   = 1'b0;
    mem_addr = r_pc;
    case (r_state)
      FETCH_OP: mem_rd = 1'b1;
      WAIT_OP: begin
        mem_addr = r_pc + 16'd1;
        mem_rd   = (w_op_len != 2'd1);
      end
      WAIT_LO: begin
        mem_addr = r_pc + 16'd2;
        mem_rd   = (r_len == 2'd3);
      end
      default: ;
    endcase
    if (rst || pc_load) mem_rd = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH_OP;
      r_pc       <= RESET_PC;
      r_opcode   <= 8'h00;
      r_operand  <= 16'h0000;
      r_instr_pc <= 16'h0000;
      r_len      <= 2'd0;
      r_illegal  <= 1'b0;
      r_valid    <= 1'b0;
    end
    else if (pc_load) begin
      r_pc    <= pc_load_value;
      r_state <= FETCH_OP;
      r_valid <= 1'b0;
    end
    else begin
      case (r_state)
        FETCH_OP: begin
          r_operand <= 16'h0000;
          r_state   <= WAIT_OP;
        end
        WAIT_OP: begin
          r_opcode   <= mem_rdata;
          r_len      <= w_op_len;
          r_illegal  <= w_op_illegal;
          r_instr_pc <= r_pc;
          if (w_op_len == 2'd1) begin
            r_state <= VALID;
            r_valid <= 1'b1;
          end
          else begin
            r_state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          r_operand[7:0] <= mem_rdata;
          if (r_len == 2'd3) begin
            r_state <= WAIT_HI;
          end
          else begin
            r_state <= VALID;
            r_valid <= 1'b1;
          end
        end
        WAIT_HI: begin
          r_operand[15:8] <= mem_rdata;
          r_state         <= VALID;
          r_valid         <= 1'b1;
        end
        VALID: begin
          // An illegal opcode parks here until redirected.
          if (instr_ready && !r_illegal) begin
            r_pc    <= r_pc + {14'd0, r_len};
            r_state <= FETCH_OP;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= FETCH_OP;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign instr_valid   = r_valid;
  assign opcode        = r_opcode;
  assign operand       = r_operand;
  assign instr_pc      = r_instr_pc;
  assign instr_len     = r_len;
  assign instr_illegal = r_illegal;

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: byte memory model with one-cycle read latency, instruction and read-address scoreboards.
// Build with FETCH_ILLEGAL_TRAP_EN to exercise the illegal-opcode trap.
module tb_cpu_fetch;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] operand;
    logic [15:0] pc;
    logic [1:0]  len;
    logic        ill;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_value = 16'h0000;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic [15:0] instr_pc;
  logic [1:0]  instr_len;
  logic        instr_illegal;

  logic [7:0]  mem [0:65535];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          first_valid_cyc = -1;
  logic        prev_valid = 1'b0;
  instr_t      exp_q [$];
  logic [15:0] rd_q [$];

  cpu_fetch #(.RESET_PC(16'h0200)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_rdata     (mem_rdata),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .operand       (operand),
    .instr_pc      (instr_pc),
    .instr_len     (instr_len),
    .instr_illegal (instr_illegal)
  );

  always #5 clk = ~clk;

  // Memory returns data one cycle after the strobe; garbage otherwise so stray latches show up.
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 8'($urandom);

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required run to complete");
    $fatal(1);
  end

  // One clock: sample at negedge (log reads, score new instructions), return just after the next rising edge.
  task automatic step();
    instr_t obs;
    instr_t want;
    @(negedge clk);
    if (mem_rd) rd_q.push_back(mem_addr);
    if (instr_valid && !prev_valid) begin
      obs = instr_t'{opcode, operand, instr_pc, instr_len, instr_illegal};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got instr %h at cycle %0d, required none", obs, cyc);
      end
      else begin
        want = exp_q.pop_front();
        if (obs !== want) begin
          errors++;
          $display("FAIL sb_instr: got op=%h opr=%h pc=%h len=%0d ill=%b, required op=%h opr=%h pc=%h len=%0d ill=%b",
                   obs.op, obs.operand, obs.pc, obs.len, obs.ill,
                   want.op, want.operand, want.pc, want.len, want.ill);
        end
      end
    end
    if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    prev_valid = instr_valid;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    pc_load = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst             = 1'b0;
    cyc             = 0;
    first_valid_cyc = -1;
    prev_valid      = 1'b0;
    rd_q.delete();
  endtask

  function automatic bit reads_equal(input logic [15:0] want [$]);
    if (rd_q.size() != want.size()) return 1'b0;
    foreach (want[i]) if (rd_q[i] !== want[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    logic [15:0] want [$];
    want = '{16'h0200, 16'h0201, 16'h0202, 16'h0203};
    mem[16'h0200] = 8'hAD; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12; mem[16'h0203] = 8'hEA;
    rst = 1'b1; pc_load = 1'b1; pc_load_value = 16'h4444; instr_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({instr_valid, mem_rd, opcode, operand, instr_pc, instr_len, instr_illegal} !== 45'd0 ||
        mem_addr !== 16'h0200) begin
      errors++;
      $display("FAIL reset_state: got valid=%b rd=%b op=%h opr=%h ipc=%h len=%0d ill=%b addr=%h, required zeros and addr=0200",
               instr_valid, mem_rd, opcode, operand, instr_pc, instr_len, instr_illegal, mem_addr);
    end
    rst = 1'b0; pc_load = 1'b0;
    run(2);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({instr_valid, mem_rd, opcode, operand, instr_pc, instr_len} !== 44'd0 || mem_addr !== 16'h0200) begin
      errors++;
      $display("FAIL reset_midfetch: got valid=%b rd=%b op=%h opr=%h ipc=%h len=%0d addr=%h, required zeros and addr=0200",
               instr_valid, mem_rd, opcode, operand, instr_pc, instr_len, mem_addr);
    end
    do_reset();
    exp_q.push_back(instr_t'{8'hAD, 16'h1234, 16'h0200, 2'd3, 1'b0});
    run(6);
    checks++;
    if (!reads_equal(want)) begin
      errors++;
      $display("FAIL reset_refetch_reads: got %p, required %p", rd_q, want);
    end
  endtask

  task automatic test_len1();
    logic [15:0] want [$];
    want = '{16'h0200, 16'h0201};
    mem[16'h0200] = 8'hEA; mem[16'h0201] = 8'hEA; mem[16'h0202] = 8'hEA;
    instr_ready = 1'b1;
    do_reset();
    exp_q.push_back(instr_t'{8'hEA, 16'h0000, 16'h0200, 2'd1, 1'b0});
    exp_q.push_back(instr_t'{8'hEA, 16'h0000, 16'h0201, 2'd1, 1'b0});
    run(6);
    checks++;
    if (first_valid_cyc != 2) begin
      errors++;
      $display("FAIL len1_latency: got cycle %0d, required 2", first_valid_cyc);
    end
    checks++;
    if (!reads_equal(want)) begin
      errors++;
      $display("FAIL len1_reads: got %p, required %p", rd_q, want);
    end
  endtask

  task automatic test_len3();
    logic [15:0] want [$];
    want = '{16'h0200, 16'h0201, 16'h0202, 16'h0203};
    mem[16'h0200] = 8'hAD; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12; mem[16'h0203] = 8'hEA;
    instr_ready = 1'b1;
    do_reset();
    exp_q.push_back(instr_t'{8'hAD, 16'h1234, 16'h0200, 2'd3, 1'b0});
    run(6);
    checks++;
    if (first_valid_cyc != 4) begin
      errors++;
      $display("FAIL len3_latency: got cycle %0d, required 4", first_valid_cyc);
    end
    checks++;
    if (!reads_equal(want)) begin
      errors++;
      $display("FAIL len3_reads: got %p, required %p", rd_q, want);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] want [$];
    want = '{16'h0200, 16'h0201, 16'h0202};
    mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h7F; mem[16'h0202] = 8'hEA;
    instr_ready = 1'b0;
    do_reset();
    exp_q.push_back(instr_t'{8'hA9, 16'h007F, 16'h0200, 2'd2, 1'b0});
    exp_q.push_back(instr_t'{8'hEA, 16'h0000, 16'h0202, 2'd1, 1'b0});
    run(3);
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || mem_rd !== 1'b0 || opcode !== 8'hA9 || operand !== 16'h007F ||
          instr_pc !== 16'h0200 || instr_len !== 2'd2) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b rd=%b op=%h opr=%h ipc=%h len=%0d, required 1 0 A9 007F 0200 2",
                 k, instr_valid, mem_rd, opcode, operand, instr_pc, instr_len);
      end
    end
    instr_ready = 1'b1;
    step();
    run(3);
    checks++;
    if (!reads_equal(want)) begin
      errors++;
      $display("FAIL bp_reads: got %p, required %p", rd_q, want);
    end
  endtask

  task automatic test_pc_load();
    logic [15:0] want [$];
    want = '{16'h0200, 16'h0201, 16'h8000};
    mem[16'h0200] = 8'hAD; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12; mem[16'h8000] = 8'hEA;
    instr_ready = 1'b1;
    do_reset();
    exp_q.push_back(instr_t'{8'hEA, 16'h0000, 16'h8000, 2'd1, 1'b0});
    run(2);
    pc_load = 1'b1; pc_load_value = 16'h8000;
    #1;
    checks++;
    if (mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL load_rd_suppress: got mem_rd=%b, required 0", mem_rd);
    end
    step();
    pc_load = 1'b0;
    #1;
    checks++;
    if (mem_addr !== 16'h8000 || mem_rd !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_redirect: got addr=%h rd=%b valid=%b, required 8000 1 0", mem_addr, mem_rd, instr_valid);
    end
    run(3);
    checks++;
    if (!reads_equal(want)) begin
      errors++;
      $display("FAIL load_reads: got %p, required %p", rd_q, want);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want [$];
    want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'hC0; mem[16'h0001] = 8'hEA;
    mem[16'h1234] = 8'h00;
    instr_ready = 1'b1;
    do_reset();
    exp_q.push_back(instr_t'{8'h4C, 16'hC000, 16'hFFFE, 2'd3, 1'b0});
    pc_load = 1'b1; pc_load_value = 16'h1234;
    step();
    pc_load_value = 16'hFFFE;
    step();
    pc_load = 1'b0;
    run(6);
    checks++;
    if (!reads_equal(want)) begin
      errors++;
      $display("FAIL wrap_reads: got %p, required %p", rd_q, want);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] want [$];
    want = '{16'h0200, 16'h0201};
    mem[16'h0200] = 8'hFF; mem[16'h0201] = 8'hEA;
    instr_ready = 1'b1;
    do_reset();
`ifdef FETCH_ILLEGAL_TRAP_EN
    exp_q.push_back(instr_t'{8'hFF, 16'h0000, 16'h0200, 2'd1, 1'b1});
    exp_q.push_back(instr_t'{8'hEA, 16'h0000, 16'h0201, 2'd1, 1'b0});
    run(3);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_illegal !== 1'b1 || mem_rd !== 1'b0) begin
        errors++;
        $display("FAIL trap_hold[%0d]: got valid=%b ill=%b rd=%b, required 1 1 0", k, instr_valid, instr_illegal, mem_rd);
      end
      step();
    end
    pc_load = 1'b1; pc_load_value = 16'h0201;
    step();
    pc_load = 1'b0;
    run(3);
`else
    exp_q.push_back(instr_t'{8'hFF, 16'h0000, 16'h0200, 2'd1, 1'b0});
    exp_q.push_back(instr_t'{8'hEA, 16'h0000, 16'h0201, 2'd1, 1'b0});
    run(6);
`endif
    checks++;
    if (!reads_equal(want)) begin
      errors++;
      $display("FAIL illegal_reads: got %p, required %p", rd_q, want);
    end
  endtask

  task automatic test_len_decode();
    logic [7:0] ops  [$];
    logic [1:0] lens [$];
    logic [15:0] opr;
    ops  = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0, 8'h24, 8'h2C, 8'h08, 8'h10,
             8'h14, 8'h18, 8'h1C, 8'h01, 8'h05, 8'h09, 8'h0D, 8'h11, 8'h15, 8'h19, 8'h1D, 8'h02,
             8'h06, 8'h0A, 8'h0E, 8'h12, 8'h16, 8'h1A, 8'h1E, 8'h03, 8'hFF};
    lens = '{2'd1, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd1, 2'd2,
             2'd2, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3, 2'd3, 2'd2,
             2'd2, 2'd1, 2'd3, 2'd1, 2'd2, 2'd1, 2'd3, 2'd1, 2'd1};
    mem[16'h1001] = 8'h5A; mem[16'h1002] = 8'hA5;
    instr_ready = 1'b0;
    do_reset();
    foreach (ops[i]) begin
      mem[16'h1000] = ops[i];
      opr = (lens[i] == 2'd3) ? 16'hA55A : (lens[i] == 2'd2) ? 16'h005A : 16'h0000;
`ifdef FETCH_ILLEGAL_TRAP_EN
      exp_q.push_back(instr_t'{ops[i], opr, 16'h1000, lens[i], ops[i][1:0] == 2'b11});
`else
      exp_q.push_back(instr_t'{ops[i], opr, 16'h1000, lens[i], 1'b0});
`endif
      pc_load = 1'b1; pc_load_value = 16'h1000;
      step();
      pc_load = 1'b0;
      run(5);
    end
  endtask

  initial begin
    test_reset();
    test_len1();
    test_len3();
    test_backpressure();
    test_pc_load();
    test_wrap();
    test_illegal();
    test_len_decode();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d instructions never presented, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
